// File: rtl/alu_mc.sv
// alu_mc - multi-cycle ALU with registered result and flags.
//
// Single-cycle ops (logic, add/sub family, shifts, INC, CMP, DIV-by-zero,
// reserved) are written to the output registers at the accepting edge.
// MUL and DIV iterate once per clock in private accumulators, and only
// the final iteration updates the visible outputs.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   start_i        operation request, sampled only while busy_o=0
//   a_i, b_i       operands (WIDTH bits)
//   alu_sel_i      4-bit opcode, sampled with start_i
//   result_o       result low word / quotient
//   result_hi_o    MUL high word / DIV remainder, 0 for other ops
//   z_o n_o c_o v_o  registered zero/negative/carry(borrow)/overflow flags
//   busy_o         high while MUL/DIV iterates
//   done_o         one-cycle completion pulse
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       alu_sel_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1001;
    localparam logic [3:0] OP_ADC = 4'b1010;
    localparam logic [3:0] OP_SBB = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             done_q, done_d;

    // ---------------- single-cycle datapath ----------------
    logic             cin;
    logic [WIDTH:0]   add_sum, sub_diff, inc_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

    always_comb begin
        cin      = ((alu_sel_i == OP_ADC) || (alu_sel_i == OP_SBB)) ? c_q : 1'b0;
        add_sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
        // Borrow appears as bit WIDTH of the (WIDTH+1)-bit difference.
        sub_diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};
        inc_sum  = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (alu_sel_i)
            OP_ADD, OP_ADC: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sc_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_c   = sub_diff[WIDTH];
                sc_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sc_res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: sc_res = a_i & b_i;
            OP_OR:  sc_res = a_i | b_i;
            OP_XOR: sc_res = a_i ^ b_i;
            OP_NOT: sc_res = ~a_i;
            OP_SHL: begin
                sc_res = {a_i[WIDTH-2:0], 1'b0};
                sc_c   = a_i[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, a_i[WIDTH-1:1]};
                sc_c   = a_i[0];
            end
            OP_INC: begin
                sc_res = inc_sum[WIDTH-1:0];
                sc_c   = inc_sum[WIDTH];
                sc_v   = (a_i == {1'b0, {(WIDTH-1){1'b1}}});
            end
            default: ;
        endcase
    end

    // ---------------- iteration datapath ----------------
    // MUL: right-shifting shift-add, multiplier consumed from acc_lo LSB.
    // DIV: restoring division, dividend shifted out of acc_lo MSB,
    //      quotient bits shifted in at acc_lo LSB, remainder in acc_hi.
    logic [WIDTH:0]   mul_sum, div_sh, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] it_hi, it_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, b_q};
        div_ge    = (div_sh >= {1'b0, b_q});
        if (is_div_q) begin
            it_hi = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
            it_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ((alu_sel_i == OP_MUL) || ((alu_sel_i == OP_DIV) && (b_i != '0))) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (alu_sel_i == OP_DIV);
                        b_d      = b_i;
                        acc_hi_d = '0;
                        acc_lo_d = a_i;
                    end else if (alu_sel_i == OP_DIV) begin
                        result_d = '1;
                        hi_d     = a_i;
                        z_d      = 1'b0;
                        n_d      = 1'b1;
                        c_d      = 1'b0;
                        v_d      = 1'b1;
                        done_d   = 1'b1;
                    end else if (alu_sel_i[3:1] == 3'b111) begin
                        result_d = '0;
                        hi_d     = '0;
                        z_d      = 1'b1;
                        n_d      = 1'b0;
                        c_d      = 1'b0;
                        v_d      = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        // CMP updates flags only; result registers keep their value.
                        if (alu_sel_i != OP_CMP) begin
                            result_d = sc_res;
                            hi_d     = '0;
                        end
                        z_d    = (sc_res == '0);
                        n_d    = sc_res[WIDTH-1];
                        c_d    = sc_c;
                        v_d    = sc_v;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d    = cnt_q - CW'(1);
                acc_hi_d = it_hi;
                acc_lo_d = it_lo;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_IDLE;
                    result_d = it_lo;
                    hi_d     = it_hi;
                    done_d   = 1'b1;
                    if (is_div_q) begin
                        z_d = (it_lo == '0);
                        n_d = it_lo[WIDTH-1];
                        c_d = 1'b0;
                        v_d = 1'b0;
                    end else begin
                        z_d = ({it_hi, it_lo} == '0);
                        n_d = it_hi[WIDTH-1];
                        c_d = (it_hi != '0);
                        v_d = (it_hi != '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            result_q <= '0;
            hi_q     <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign result_o    = result_q;
    assign result_hi_o = hi_q;
    assign z_o         = z_q;
    assign n_o         = n_q;
    assign c_o         = c_q;
    assign v_o         = v_q;
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = done_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic [3:0] sel;
    logic [7:0] result, result_hi;
    logic       z, n, c, v, busy, done;

    alu_mc #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .a_i(a), .b_i(b), .alu_sel_i(sel),
        .result_o(result), .result_hi_o(result_hi),
        .z_o(z), .n_o(n), .c_o(c), .v_o(v),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] h;
        logic       z, n, c, v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_hi  = 8'h00;
    logic       m_c   = 1'b0;

    function automatic exp_t observed();
        return {result, result_hi, z, n, c, v};
    endfunction

    task automatic predict(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
        exp_t e;
        int s;
        logic [7:0] r;
        logic [15:0] p;
        e = {m_res, m_hi, 1'b0, 1'b0, 1'b0, 1'b0};
        r = 8'h00;
        case (op)
            4'd0, 4'd10, 4'd8: begin
                if (op == 4'd8) s = int'(ia) + 1;
                else            s = int'(ia) + int'(ib) + ((op == 4'd10) ? int'(m_c) : 0);
                r = s[7:0];
                e.c = (s > 255);
                if (op == 4'd8) e.v = (ia == 8'h7F);
                else            e.v = (ia[7] == ib[7]) && (r[7] != ia[7]);
            end
            4'd1, 4'd9, 4'd11: begin
                s = int'(ia) - int'(ib) - ((op == 4'd11) ? int'(m_c) : 0);
                r = s[7:0];
                e.c = (s < 0);
                e.v = (ia[7] != ib[7]) && (r[7] != ia[7]);
            end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: r = ~ia;
            4'd6: begin r = {ia[6:0], 1'b0}; e.c = ia[7]; end
            4'd7: begin r = {1'b0, ia[7:1]}; e.c = ia[0]; end
            default: ;
        endcase
        if (op <= 4'd11) begin
            e.z = (r == 8'h00);
            e.n = r[7];
            if (op != 4'd9) begin
                e.r = r;
                e.h = 8'h00;
            end
        end else if (op == 4'd12) begin
            p = 16'(ia) * 16'(ib);
            e.r = p[7:0];
            e.h = p[15:8];
            e.z = (p == 16'h0000);
            e.n = p[15];
            e.c = (p[15:8] != 8'h00);
            e.v = e.c;
        end else if (op == 4'd13) begin
            if (ib == 8'h00) begin
                e.r = 8'hFF; e.h = ia; e.z = 1'b0; e.n = 1'b1; e.c = 1'b0; e.v = 1'b1;
            end else begin
                e.r = ia / ib;
                e.h = ia % ib;
                e.z = (e.r == 8'h00);
                e.n = e.r[7];
            end
        end else begin
            e.r = 8'h00; e.h = 8'h00; e.z = 1'b1;
        end
        m_res = e.r;
        m_hi  = e.h;
        m_c   = e.c;
        sb.push_back(e);
    endtask

    // Drives one op for one cycle; returns whether done arrived and the
    // number of edges between acceptance and the done edge.
    task automatic run_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                          output logic ok, output int lat);
        @(negedge clk);
        sel = op; a = ia; b = ib; start = 1'b1;
        predict(op, ia, ib);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; sel = 4'd0;
        #2;
        n_cmp++;
        if ({observed(), busy, done} !== 23'h0) begin
            n_bad++;
            $display("FAIL reset: got %h exp 0", {observed(), busy, done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        logic ok; int lat; exp_t e;
        run_op(4'd0, 8'h7F, 8'h01, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || lat != 0 || observed() !== e || e !== {8'h80, 8'h00, 4'b0101}) begin
            n_bad++;
            $display("FAIL add_ovf: got %h lat %0d ok %0d exp %h", observed(), lat, ok, e);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL add_done_pulse: got done %b exp 0", done);
        end
    endtask

    task automatic test_carry_chain();
        logic ok; int lat; exp_t e;
        logic [3:0] ops [3] = '{4'd0, 4'd10, 4'd11};
        logic [7:0] as  [3] = '{8'hFF, 8'h00, 8'h00};
        logic [7:0] bs  [3] = '{8'h01, 8'h00, 8'h00};
        exp_t       ref_v [3] = '{{8'h00, 8'h00, 4'b1010}, {8'h01, 8'h00, 4'b0000},
                                  {8'h00, 8'h00, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], ok, lat);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || lat != 0 || observed() !== e || e !== ref_v[i]) begin
                n_bad++;
                $display("FAIL carry_chain[%0d]: got %h lat %0d exp %h", i, observed(), lat, ref_v[i]);
            end
        end
    endtask

    task automatic test_mul_busy();
        exp_t e;
        int lat, busy_cnt;
        logic held_ok;
        logic [7:0] prev_r;
        prev_r = m_res;
        busy_cnt = 0;
        held_ok = 1'b1;
        @(negedge clk);
        sel = 4'd12; a = 8'hFF; b = 8'hFF; start = 1'b1;
        predict(4'd12, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (result !== prev_r) held_ok = 1'b0;
            @(negedge clk);
            // a different request while busy must be ignored
            if (lat == 3) begin sel = 4'd0; a = 8'h01; b = 8'h01; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e || e !== {8'h01, 8'hFE, 4'b0111}) begin
            n_bad++;
            $display("FAIL mul: got %h exp %h", observed(), e);
        end
        n_cmp++;
        if (lat != 8 || busy_cnt != 8 || busy !== 1'b0 || !held_ok) begin
            n_bad++;
            $display("FAIL mul_timing: got lat %0d busy_cycles %0d busy %b held %b exp 8 8 0 1",
                     lat, busy_cnt, busy, held_ok);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_no_queue: got done %b busy %b exp 0 0", done, busy);
        end
    endtask

    task automatic test_div();
        logic ok; int lat; exp_t e;
        run_op(4'd13, 8'd100, 8'd7, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || lat != 8 || observed() !== e || e !== {8'h0E, 8'h02, 4'b0000}) begin
            n_bad++;
            $display("FAIL div: got %h lat %0d exp %h", observed(), lat, e);
        end
        run_op(4'd13, 8'h05, 8'h00, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || lat != 0 || busy !== 1'b0 || observed() !== e || e !== {8'hFF, 8'h05, 4'b0101}) begin
            n_bad++;
            $display("FAIL div0: got %h lat %0d busy %b exp %h", observed(), lat, busy, e);
        end
    endtask

    task automatic test_cmp_shift();
        logic ok; int lat; exp_t e;
        run_op(4'd3, 8'h50, 8'h05, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || observed() !== e) begin
            n_bad++;
            $display("FAIL or55: got %h exp %h", observed(), e);
        end
        run_op(4'd9, 8'h10, 8'h20, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || observed() !== e || e !== {8'h55, 8'h00, 4'b0110}) begin
            n_bad++;
            $display("FAIL cmp: got %h exp %h", observed(), e);
        end
        run_op(4'd7, 8'h01, 8'h00, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || observed() !== e || e !== {8'h00, 8'h00, 4'b1010}) begin
            n_bad++;
            $display("FAIL shr: got %h exp %h", observed(), e);
        end
    endtask

    task automatic test_reset_mid_run();
        logic ok; int lat; exp_t e;
        int stray;
        @(negedge clk);
        sel = 4'd12; a = 8'h23; b = 8'h11; start = 1'b1;
        predict(4'd12, 8'h23, 8'h11);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({observed(), busy, done} !== 23'h0) begin
            n_bad++;
            $display("FAIL rst_mid_run: got %h exp 0", {observed(), busy, done});
        end
        void'(sb.pop_front());
        m_res = 8'h00; m_hi = 8'h00; m_c = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL rst_no_done: got %0d active cycles exp 0", stray);
        end
        run_op(4'd0, 8'h02, 8'h03, ok, lat);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || lat != 0 || observed() !== e || e.r !== 8'h05) begin
            n_bad++;
            $display("FAIL add_after_rst: got %h lat %0d exp %h", observed(), lat, e);
        end
    endtask

    task automatic test_back_to_back();
        logic ok; int lat; exp_t e;
        logic [3:0] op;
        logic [7:0] ia, ib;
        int exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ia = 8'($urandom);
            ib = 8'($urandom);
            if (i % 7 == 0) ia = 8'h7F;
            if (op == 4'd13 && i % 3 == 0) ib = 8'h00;
            exp_lat = (op == 4'd12 || (op == 4'd13 && ib != 8'h00)) ? 8 : 0;
            run_op(op, ia, ib, ok, lat);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || lat != exp_lat || observed() !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d] op %0d a %h b %h: got %h lat %0d exp %h lat %0d",
                         i, op, ia, ib, observed(), lat, e, exp_lat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_carry_chain();
        test_mul_busy();
        test_div();
        test_cmp_shift();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the 8-bit combinational ALU in the datapath. Takes operands from the A/B operand muxes and holds results and Z/N/C/V flags in registers. Adds carry-chained ADC/SBB, iterative unsigned MUL and DIV, and a start/busy/done handshake so the control unit can wait on long operations.

## Interface
- WIDTH, 8, operand/result width in bits (≥4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- A  in  WIDTH  operand A (operand mux A)
- B  in  WIDTH  operand B (operand mux B)
- ALU_Sel  in  4  operation select, sampled with start
- Result  out  WIDTH  result low word / quotient
- ResultHi  out  WIDTH  MUL high word / DIV remainder; 0 for other ops
- Z, N, C, V  out  1 each  registered flags: zero, negative, carry/borrow, overflow
- busy  out  1  high while MUL/DIV iterates
- done  out  1  one-cycle pulse when an operation completes

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT A
  - 0110 SHL
  - 0111 SHR
  - 1000 INC A
  - 1001 CMP
  - 1010 ADC
  - 1011 SBB
  - 1100 MUL
  - 1101 DIV
  - 1110/1111 reserved
- Arithmetic is modulo 2^WIDTH.
- C is carry-out for ADD/INC/ADC and borrow (A < B+cin, unsigned) for SUB/CMP/SBB.
- V is signed overflow:
  - ADD/ADC: operand signs equal and result sign differs.
  - SUB/SBB/CMP: operand signs differ and result sign differs from A.
  - INC: A == 0111…1.
- ADC computes A+B+C_reg. SBB computes A−B−C_reg. C_reg is the flag value before the operation.
- SHL: Result = A<<1, C = A[WIDTH-1]. SHR (logical): Result = A>>1, C = A[0]. V=0 for both.
- AND/OR/XOR/NOT: C=0, V=0.
- For every op except CMP, MUL and DIV: Z = (Result==0), N = Result[WIDTH-1], ResultHi = 0.
- CMP: updates Z/N/C/V exactly as SUB would. Result and ResultHi keep their previous values.
- MUL: unsigned shift-add, WIDTH iterations, 2·WIDTH-bit product in {ResultHi, Result}.
  - Z = (product==0), N = ResultHi[WIDTH-1].
  - C = V = (ResultHi != 0).
- DIV: unsigned restoring division, WIDTH iterations. Result = quotient, ResultHi = remainder.
  - Z = (quotient==0), N = quotient[WIDTH-1], C = 0, V = 0.
- DIV with B==0: no iteration. Result = all ones, ResultHi = A, V = 1, C = 0, Z = 0, N = 1. Completes with single-cycle latency.
- Reserved opcodes: Result = 0, ResultHi = 0, Z = 1, N = C = V = 0. Completes with single-cycle latency.
- A, B and ALU_Sel are captured internally at acceptance. Changes to them while busy have no effect.
- States:
  - IDLE: start=1 with a single-cycle op (including DIV-by-zero) → results written at that edge, stay in IDLE. start=1 with MUL or DIV (B≠0) → RUN, iteration counter loaded with WIDTH.
  - RUN: one iteration per clock. On the final iteration, results and flags are written → IDLE.

## Timing
- Reset values (asynchronous, immediate): Result=0, ResultHi=0, Z=N=C=V=0, busy=0, done=0, state=IDLE, counter=0.
- Single-cycle ops: accepted at edge k. Result, flags and done=1 are visible after edge k. done is low after edge k+1 unless a new op is accepted.
- MUL/DIV: accepted at edge k. busy=1 from edge k to edge k+WIDTH. Results, flags and done=1 appear after edge k+WIDTH, together with busy=0. Latency is WIDTH cycles.
- A new start may be accepted in the same cycle done is high, giving back-to-back throughput.
- start while busy=1 is ignored: no queuing and no error.
- Outputs hold their last completed values between operations. They are never visible in a partial state during RUN, because internal accumulators are separate registers.
- rst asserted mid-RUN: the operation is aborted, outputs go to reset values, and no done pulse is produced.

## Test plan
- ADD, WIDTH=8, A=0x7F, B=0x01, start one cycle → next cycle Result=0x80, N=1, V=1, C=0, Z=0, done=1 for exactly one cycle.
- ADD 0xFF+0x01 → Result=0x00, Z=1, C=1. Then ADC 0x00+0x00 → Result=0x01, C=0, Z=0. Then SBB 0x00−0x00 with C=0 → Result=0x00, Z=1.
- MUL 0xFF×0xFF → busy high for 8 cycles. done after edge k+8 with ResultHi=0xFE, Result=0x01, C=V=1. A start pulse mid-run is ignored.
- DIV 100/7 → after 8 cycles, Result=0x0E, ResultHi=0x02, Z=0. DIV 0x05/0x00 → one cycle later, Result=0xFF, ResultHi=0x05, V=1, busy never asserted.
- CMP A=0x10, B=0x20 after a prior Result=0x55 → Result stays 0x55, C=1, N=1, Z=0, V=0. SHR 0x01 → Result=0x00, C=1, Z=1.
- Start MUL, assert rst at iteration 3 → all outputs 0 immediately, busy=0, no done. After release, ADD 0x02+0x03 → Result=0x05 one cycle after start.
